ptch_pid: RTL

- Balance controller stage directly downstream of the inertial interface.
- Consumes the integrated pitch word and its one-cycle valid strobe.
- Computes a saturated signed PID drive command; the motor-drive logic consumes that command.
- Three-stage registered pipeline with an 18-bit integrator and a two-deep error history for the derivative term.

---
 rtl/ptch_pid.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ptch_pid.sv
// Pitch PID stage: 3-cycle IDLE/TERMS/SUM pipeline producing a saturated 12-bit drive command.
// Optional soft-start output scaling is enabled with `define PID_SOFT_START_EN.
module ptch_pid #(
    parameter int P_COEFF  = 12,
    parameter int D_COEFF  = 20,
    parameter int SS_SHIFT = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic               pwr_up,
    input  logic               rider_off,
    output logic        [11:0] PID_cntrl,
    output logic               out_vld,
    output logic        [7:0]  ss_tmr
);
    typedef enum logic [1:0] {IDLE, TERMS, SUM} state_t;

    localparam logic signed [14:0] PC = 15'(P_COEFF);
    localparam logic signed [14:0] DC = 15'(D_COEFF);

    state_t             state_q, state_d;
    logic signed [9:0]  err_q, err_d, hist0_q, hist0_d, hist1_q, hist1_d;
    logic signed [17:0] integ_q, integ_d;
    logic signed [14:0] p_q, p_d, i_q, i_d, d_q, d_d;
    logic signed [11:0] pid_q, pid_d;
    logic               out_vld_q, out_vld_d;

    logic signed [9:0]  err_sat;
    logic signed [17:0] integ_sum, integ_new;
    logic               integ_ovf;
    logic signed [10:0] d_diff;
    logic signed [6:0]  d_sat;
    logic signed [14:0] p_calc, i_calc, d_calc;
    logic signed [15:0] sum16;
    logic signed [11:0] sat_sum, pid_out;

    assign err_sat = (ptch > 16'sd511)  ? 10'sd511 :
                     (ptch < -16'sd512) ? -10'sd512 : ptch[9:0];

    // Overflow only possible when both operands share a sign; then hold instead of wrapping.
    assign integ_sum = integ_q + {{8{err_q[9]}}, err_q};
    assign integ_ovf = (integ_q[17] == err_q[9]) && (integ_sum[17] != integ_q[17]);
    assign integ_new = integ_ovf ? integ_q : integ_sum;
    assign i_calc    = {{3{integ_new[17]}}, integ_new[17:6]};

    assign d_diff = {err_q[9], err_q} - {hist1_q[9], hist1_q};
    assign d_sat  = (d_diff > 11'sd63)  ? 7'sd63 :
                    (d_diff < -11'sd64) ? -7'sd64 : d_diff[6:0];
    assign d_calc = d_sat * DC;
    assign p_calc = err_q * PC;

    assign sum16   = {p_q[14], p_q} + {i_q[14], i_q} + {d_q[14], d_q};
    assign sat_sum = (sum16 > 16'sd2047)  ? 12'sd2047 :
                     (sum16 < -16'sd2048) ? -12'sd2048 : sum16[11:0];

`ifdef PID_SOFT_START_EN
    logic [SS_SHIFT-1:0] pre_q;
    logic [7:0]          ss_q;
    logic signed [19:0]  prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ss_q  <= '0;
        end else if (!pwr_up) begin
            pre_q <= '0;
            ss_q  <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
            if ((&pre_q) && (ss_q != 8'hFF)) ss_q <= ss_q + 8'd1;
        end
    end

    assign prod    = sat_sum * $signed({1'b0, ss_q});
    assign pid_out = (ss_q == 8'hFF) ? sat_sum : 12'(prod >>> 8);
    assign ss_tmr  = ss_q;
`else
    assign pid_out = sat_sum;
    assign ss_tmr  = 8'hFF;
`endif

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        integ_d   = integ_q;
        hist0_d   = hist0_q;
        hist1_d   = hist1_q;
        p_d       = p_q;
        i_d       = i_q;
        d_d       = d_q;
        pid_d     = pid_q;
        out_vld_d = 1'b0;
        case (state_q)
            IDLE: if (vld) begin
                state_d = TERMS;
                err_d   = err_sat;
            end
            TERMS: begin
                state_d = SUM;
                // Zeroed terms make SUM produce 0 with no separate force path.
                if (!pwr_up || rider_off) begin
                    integ_d = '0;
                    hist0_d = '0;
                    hist1_d = '0;
                    p_d     = '0;
                    i_d     = '0;
                    d_d     = '0;
                end else begin
                    integ_d = integ_new;
                    hist1_d = hist0_q;
                    hist0_d = err_q;
                    p_d     = p_calc;
                    i_d     = i_calc;
                    d_d     = d_calc;
                end
            end
            SUM: begin
                state_d   = IDLE;
                pid_d     = pid_out;
                out_vld_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_q     <= '0;
            integ_q   <= '0;
            hist0_q   <= '0;
            hist1_q   <= '0;
            p_q       <= '0;
            i_q       <= '0;
            d_q       <= '0;
            pid_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            integ_q   <= integ_d;
            hist0_q   <= hist0_d;
            hist1_q   <= hist1_d;
            p_q       <= p_d;
            i_q       <= i_d;
            d_q       <= d_d;
            pid_q     <= pid_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign PID_cntrl = pid_q;
    assign out_vld   = out_vld_q;
endmodule
